// File: rtl/karatsuba_combine_32_if.sv
`default_nettype none
// ============================================================================
//  Module      : karatsuba_combine_32_if
//  Description : Handshake/data bundle for the Karatsuba recombination stage.
//                The err signal exists only when KCOMB_MID_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface karatsuba_combine_32_if #(
    parameter int W  = 32,
    parameter int WM = 34
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    z0;
    logic [WM-1:0]   z1;
    logic [W-1:0]    z2;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  p;
    logic            busy;
`ifdef KCOMB_MID_CHECK_EN
    logic            err;

    modport master (
        output in_valid, z0, z1, z2, out_ready,
        input  in_ready, out_valid, p, busy, err
    );
    modport slave (
        input  in_valid, z0, z1, z2, out_ready,
        output in_ready, out_valid, p, busy, err
    );
`else
    modport master (
        output in_valid, z0, z1, z2, out_ready,
        input  in_ready, out_valid, p, busy
    );
    modport slave (
        input  in_valid, z0, z1, z2, out_ready,
        output in_ready, out_valid, p, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/karatsuba_combine_32.sv
`default_nettype none
// ============================================================================
//  Module      : karatsuba_combine_32
//  Description : Karatsuba recombination P = z2<<32 + (z1-z0-z2)<<16 + z0,
//                sequenced over four steps through one shared 32-bit adder.
//                Optional macro KCOMB_MID_CHECK_EN adds a sticky err flag for
//                a negative middle term.
//  Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_combine_32 #(
    parameter int W  = 32,
    parameter int WM = 34
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    karatsuba_combine_32_if.slave  bus
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_sub0 = 3'd1;
    localparam logic [2:0] c_st_sub2 = 3'd2;
    localparam logic [2:0] c_st_addl = 3'd3;
    localparam logic [2:0] c_st_addh = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    logic [2:0]     r_state;
    logic [2:0]     w_next_state;

    logic [W-1:0]   r_z0;
    logic [WM-1:0]  r_z1;
    logic [W-1:0]   r_z2;
    logic [WM-1:0]  r_mid;
    logic           r_c1;
    logic [2*W-1:0] r_p;

    logic [W-1:0]   w_add_a;
    logic [W-1:0]   w_add_b;
    logic           w_add_cin;
    logic [W:0]     w_add_sum;
    logic [1:0]     w_mid_hi_base;
    logic [1:0]     w_mid_hi;

    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_busy;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (bus.in_valid) w_next_state = c_st_sub0;
            c_st_sub0: w_next_state = c_st_sub2;
            c_st_sub2: w_next_state = c_st_addl;
            c_st_addl: w_next_state = c_st_addh;
            c_st_addh: w_next_state = c_st_done;
            c_st_done: if (bus.out_ready) w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == c_st_idle);
        w_busy      = (r_state != c_st_idle);
        w_out_valid = (r_state == c_st_done);
    end

    // ------------------------------------------------------- shared adder
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            c_st_sub0: begin
                w_add_a   = r_z1[W-1:0];
                w_add_b   = ~r_z0;
                w_add_cin = 1'b1;
            end
            c_st_sub2: begin
                w_add_a   = r_mid[W-1:0];
                w_add_b   = ~r_z2;
                w_add_cin = 1'b1;
            end
            c_st_addl: begin
                w_add_a   = {r_z2[15:0], r_z0[31:16]};
                w_add_b   = r_mid[W-1:0];
            end
            c_st_addh: begin
                w_add_a   = {16'b0, r_z2[31:16]};
                w_add_b   = {30'b0, r_mid[33:32]};
                w_add_cin = r_c1;
            end
            default: ;
        endcase
    end

    assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{W{1'b0}}, w_add_cin};

    // Upper two bits of the 34-bit subtract: adding 2'b11 is the sign
    // extension of the inverted 32-bit subtrahend.
    assign w_mid_hi_base = (r_state == c_st_sub0) ? r_z1[33:32] : r_mid[33:32];
    assign w_mid_hi      = w_mid_hi_base + 2'b11 + {1'b0, w_add_sum[W]};

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z0  <= '0;
            r_z1  <= '0;
            r_z2  <= '0;
            r_mid <= '0;
            r_c1  <= 1'b0;
            r_p   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_z0 <= bus.z0;
                        r_z1 <= bus.z1;
                        r_z2 <= bus.z2;
                    end
                end
                c_st_sub0, c_st_sub2: begin
                    r_mid <= {w_mid_hi, w_add_sum[W-1:0]};
                end
                c_st_addl: begin
                    r_p[47:16] <= w_add_sum[W-1:0];
                    r_p[15:0]  <= r_z0[15:0];
                    r_c1       <= w_add_sum[W];
                end
                c_st_addh: begin
                    r_p[63:48] <= w_add_sum[15:0];
                end
                default: ;
            endcase
        end
    end

`ifdef KCOMB_MID_CHECK_EN
    logic r_err;

    // A legal middle term is non-negative, so bit 33 after SUB2 flags bad inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == c_st_sub2 && w_mid_hi[1]) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_combine_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_karatsuba_combine_32
//  Description : Scoreboard bench for karatsuba_combine_32 (directed + random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_karatsuba_combine_32;

    typedef struct {
        logic [63:0] p;
        time         t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    karatsuba_combine_32_if bus();

    karatsuba_combine_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level reference: 34-bit wrapping middle term, 64-bit wrapping sum.
    function automatic logic [63:0] model(input logic [31:0] a0, input logic [33:0] a1,
                                          input logic [31:0] a2);
        logic [33:0] mid;
        mid = a1 - {2'b00, a0} - {2'b00, a2};
        return ({32'b0, a2} << 32) + ({30'b0, mid} << 16) + {32'b0, a0};
    endfunction

    // ------------------------------------------------------------ monitor
    logic        ov_prev, hold_prev, hs_prev;
    logic [63:0] hold_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev   = 1'b0;
            hold_prev = 1'b0;
            hs_prev   = 1'b0;
        end else begin
            chk("busy_vs_ready", {63'b0, bus.busy}, {63'b0, ~bus.in_ready});
            if (hs_prev)
                chk("ready_after_done", {63'b0, bus.in_ready}, 64'd1);
            if (hold_prev) begin
                chk("hold_valid", {63'b0, bus.out_valid}, 64'd1);
                chk("hold_p", bus.p, hold_p);
            end
            if (bus.out_valid)
                chk("in_ready_in_done", {63'b0, bus.in_ready}, 64'd0);
            if (bus.out_valid && !ov_prev) begin
                if (sb.size() == 0)
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                else
                    chk("latency", ($time - sb[0].t) / 10, 64'd5);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_product", bus.p, 64'hx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", bus.p, e.p);
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_p    = bus.p;
            hs_prev   = bus.out_valid && bus.out_ready;
            ov_prev   = bus.out_valid;
        end
    end

    // ------------------------------------------------------------- driver
    task automatic send(input logic [31:0] a0, input logic [33:0] a1,
                        input logic [31:0] a2, input logic [63:0] exp_p);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.z0 = a0;
        bus.z1 = a1;
        bus.z2 = a2;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'd1, 64'd0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.p = exp_p;
        e.t = $time;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.z0 = $urandom;
        bus.z1 = {$urandom_range(0, 3), $urandom};
        bus.z2 = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
            end
        end
        @(negedge clk);
    endtask

    // -------------------------------------------------------------- main
    initial begin
        logic [31:0] a, b, z0v, z2v;
        logic [33:0] z1v;
        logic [16:0] sa, sbv;
        int n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.z0        = '0;
        bus.z1        = '0;
        bus.z2        = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready",  {63'b0, bus.in_ready},  64'd1);
        chk("reset_busy",      {63'b0, bus.busy},      64'd0);
        chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("reset_p",         bus.p,                  64'd0);
`ifdef KCOMB_MID_CHECK_EN
        chk("reset_err",       {63'b0, bus.err},       64'd0);
`endif
        rst_n = 1'b1;

        // directed products
        send(32'd15, 34'd15, 32'd0, 64'h0000_0000_0000_000F);
        drain();
        send(32'd0, 34'd1, 32'd1, 64'h0000_0001_0000_0000);
        drain();
        send(32'hFFFE0001, 34'h3_FFF8_0004, 32'hFFFE0001, 64'hFFFF_FFFE_0000_0001);
        drain();

        // backpressure: hold DONE for 10 cycles
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'h1234_5678, 34'h1_0000_0000, 32'h0000_1111,
             model(32'h1234_5678, 34'h1_0000_0000, 32'h0000_1111));
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", {63'b0, bus.out_valid}, 64'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // reset while in SUB2 aborts the job
        send(32'hDEAD_BEEF, 34'h2_0000_0000, 32'h0BAD_F00D, 64'd0);
        repeat (2) @(negedge clk);
        chk("sub2_busy", {63'b0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_in_ready",  {63'b0, bus.in_ready},  64'd1);
        chk("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("abort_p",         bus.p,                  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(32'd15, 34'd15, 32'd0, 64'h0000_0000_0000_000F);
        drain();

`ifdef KCOMB_MID_CHECK_EN
        chk("err_before_bad", {63'b0, bus.err}, 64'd0);
        send(32'd1, 34'd0, 32'd0, 64'h0003_FFFF_FFFF_0001);
        drain();
        chk("err_after_bad", {63'b0, bus.err}, 64'd1);
        send(32'd15, 34'd15, 32'd0, 64'h0000_0000_0000_000F);
        drain();
        chk("err_sticky", {63'b0, bus.err}, 64'd1);
`endif

        // random legal Karatsuba inputs: expected value is the true product
        for (int i = 0; i < 30; i++) begin
            a   = $urandom;
            b   = $urandom;
            z0v = {16'b0, a[15:0]} * {16'b0, b[15:0]};
            z2v = {16'b0, a[31:16]} * {16'b0, b[31:16]};
            sa  = {1'b0, a[15:0]} + {1'b0, a[31:16]};
            sbv = {1'b0, b[15:0]} + {1'b0, b[31:16]};
            z1v = {17'b0, sa} * {17'b0, sbv};
            send(z0v, z1v, z2v, {32'b0, a} * {32'b0, b});
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        // random arbitrary inputs: wrapping arithmetic
        for (int i = 0; i < 10; i++) begin
            z0v = $urandom;
            z2v = $urandom;
            z1v = {$urandom_range(0, 3), $urandom};
            send(z0v, z1v, z2v, model(z0v, z1v, z2v));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
